// File: rtl/dual_port_ram.sv
// Dual-port RAM: read-only instruction port, read/write data port with byte strobes,
// READ_LAT of 1 or 2, clear sweep after reset. Define MEM_ERR_EN to add data-port address checking (data_err).
module dual_port_ram #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 1024,
   parameter int ADDR_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  init_done,
   input  logic                  inst_req,
   input  logic [ADDR_W-1:0]     inst_addr,
   output logic                  inst_valid,
   output logic [DATA_W-1:0]     inst_data,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [DATA_W/8-1:0]   data_be,
   input  logic [ADDR_W-1:0]     data_addr,
   input  logic [DATA_W-1:0]     data_wdata,
   output logic                  data_valid,
   output logic [DATA_W-1:0]     data_rdata
`ifdef MEM_ERR_EN
   ,
   output logic                  data_err
`endif
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int NB    = DATA_W / 8;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [0:0]        state_r;
   logic [IDX_W-1:0]  cnt_r;
   logic              init_done_r;

   logic [IDX_W-1:0]  inst_idx_s;
   logic [IDX_W-1:0]  data_idx_s;
   logic              err_s;
   logic              inst_rd_s;
   logic              data_rd_s;
   logic              data_wr_s;
   logic              data_bad_s;
   logic              unused_s;

   logic              inst_v1_r;
   logic [DATA_W-1:0] inst_d1_r;
   logic              data_v1_r;
   logic [DATA_W-1:0] data_d1_r;
   logic              err1_r;
   logic              err_out_s;

   assign inst_idx_s = inst_addr[IDX_W+1:2];
   assign data_idx_s = data_addr[IDX_W+1:2];

`ifdef MEM_ERR_EN
   assign err_s    = (data_addr[1:0] != 2'b00) || (|data_addr[ADDR_W-1:IDX_W+2]);
   assign unused_s = ^{inst_addr[ADDR_W-1:IDX_W+2], inst_addr[1:0], err_out_s};
   assign data_err = err_out_s;
`else
   assign err_s    = 1'b0;
   assign unused_s = ^{inst_addr[ADDR_W-1:IDX_W+2], inst_addr[1:0],
                       data_addr[ADDR_W-1:IDX_W+2], data_addr[1:0], err_out_s};
`endif

   // Requests are honoured only once the clear sweep is complete.
   assign inst_rd_s  = init_done_r && inst_req;
   assign data_rd_s  = init_done_r && data_req && !data_we;
   assign data_wr_s  = init_done_r && data_req && data_we && !err_s;
   assign data_bad_s = init_done_r && data_req && err_s;

   // Sweep sequencer: INIT clears one word per cycle, then RUN forever.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= ST_INIT;
         cnt_r       <= {IDX_W{1'b0}};
         init_done_r <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               cnt_r <= cnt_r + IDX_W'(1);
               if (cnt_r == IDX_W'(DEPTH - 1)) begin
                  state_r <= ST_RUN;
               end
            end
            ST_RUN:  state_r <= ST_RUN;
            default: state_r <= ST_INIT;
         endcase
         init_done_r <= (state_r == ST_RUN);
      end
   end

   // Array write: sweep clear during INIT, byte-strobed data writes in RUN.
   always_ff @(posedge clock) begin
      if (state_r == ST_INIT) begin
         mem[cnt_r] <= {DATA_W{1'b0}};
      end else if (data_wr_s) begin
         for (int b = 0; b < NB; b++) begin
            if (data_be[b]) begin
               mem[data_idx_s][b*8 +: 8] <= data_wdata[b*8 +: 8];
            end
         end
      end
   end

   // First read stage; reads see the array before this edge's write (read-first).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inst_v1_r <= 1'b0;
         inst_d1_r <= {DATA_W{1'b0}};
         data_v1_r <= 1'b0;
         data_d1_r <= {DATA_W{1'b0}};
         err1_r    <= 1'b0;
      end else begin
         inst_v1_r <= inst_rd_s;
         data_v1_r <= data_rd_s;
         err1_r    <= data_bad_s;
         if (inst_rd_s) begin
            inst_d1_r <= mem[inst_idx_s];
         end
         if (data_rd_s) begin
            data_d1_r <= err_s ? {DATA_W{1'b0}} : mem[data_idx_s];
         end
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic              inst_v2_r;
         logic [DATA_W-1:0] inst_d2_r;
         logic              data_v2_r;
         logic [DATA_W-1:0] data_d2_r;
         logic              err2_r;

         // Extra output stage; data registers only load on a valid beat.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               inst_v2_r <= 1'b0;
               inst_d2_r <= {DATA_W{1'b0}};
               data_v2_r <= 1'b0;
               data_d2_r <= {DATA_W{1'b0}};
               err2_r    <= 1'b0;
            end else begin
               inst_v2_r <= inst_v1_r;
               data_v2_r <= data_v1_r;
               err2_r    <= err1_r;
               if (inst_v1_r) begin
                  inst_d2_r <= inst_d1_r;
               end
               if (data_v1_r) begin
                  data_d2_r <= data_d1_r;
               end
            end
         end

         assign inst_valid = inst_v2_r;
         assign inst_data  = inst_d2_r;
         assign data_valid = data_v2_r;
         assign data_rdata = data_d2_r;
         assign err_out_s  = err2_r;
      end else begin : g_lat1
         assign inst_valid = inst_v1_r;
         assign inst_data  = inst_d1_r;
         assign data_valid = data_v1_r;
         assign data_rdata = data_d1_r;
         assign err_out_s  = err1_r;
      end
   endgenerate

   assign init_done = init_done_r;

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: READ_LAT=1 and READ_LAT=2 instances share stimulus;
// per-port scoreboards check data and arrival cycle. Define MEM_ERR_EN to exercise data_err.
module tb_dual_port_ram;
   localparam int DEPTH = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = 32'h0;
   logic        data_req = 1'b0;
   logic        data_we = 1'b0;
   logic [3:0]  data_be = 4'h0;
   logic [31:0] data_addr = 32'h0;
   logic [31:0] data_wdata = 32'h0;

   logic        init_done_a, inst_valid_a, data_valid_a;
   logic [31:0] inst_data_a, data_rdata_a;
   logic        init_done_b, inst_valid_b, data_valid_b;
   logic [31:0] inst_data_b, data_rdata_b;
`ifdef MEM_ERR_EN
   logic        data_err_a, data_err_b;
`endif

   dual_port_ram #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(1)) u1 (
      .clock(clock), .reset(reset), .init_done(init_done_a),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid_a), .inst_data(inst_data_a),
      .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_valid(data_valid_a), .data_rdata(data_rdata_a)
`ifdef MEM_ERR_EN
      , .data_err(data_err_a)
`endif
   );

   dual_port_ram #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(2)) u2 (
      .clock(clock), .reset(reset), .init_done(init_done_b),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid_b), .inst_data(inst_data_b),
      .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_valid(data_valid_b), .data_rdata(data_rdata_b)
`ifdef MEM_ERR_EN
      , .data_err(data_err_b)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   // 0: u1 inst, 1: u1 data, 2: u2 inst, 3: u2 data
   exp_t        q[4][$];
   logic        mon_v[4];
   logic [31:0] mon_d[4];

   always_comb begin
      mon_v[0] = inst_valid_a; mon_d[0] = inst_data_a;
      mon_v[1] = data_valid_a; mon_d[1] = data_rdata_a;
      mon_v[2] = inst_valid_b; mon_d[2] = inst_data_b;
      mon_v[3] = data_valid_b; mon_d[3] = data_rdata_b;
   end

   always @(negedge clock) begin
      exp_t e;
      for (int p = 0; p < 4; p++) begin
         if (mon_v[p]) begin
            if (q[p].size() == 0) begin
               check($sformatf("unexpected_valid_p%0d", p), 32'd1, 32'd0);
            end else begin
               e = q[p].pop_front();
               check($sformatf("data_p%0d", p), mon_d[p], e.d);
               check($sformatf("cycle_p%0d", p), cyc, e.due);
            end
         end
      end
   end

   task automatic exp_inst(input logic [31:0] d);
      q[0].push_back('{d: d, due: cyc + 1});
      q[2].push_back('{d: d, due: cyc + 2});
   endtask

   task automatic exp_data(input logic [31:0] d);
      q[1].push_back('{d: d, due: cyc + 1});
      q[3].push_back('{d: d, due: cyc + 2});
   endtask

`ifdef MEM_ERR_EN
   int eq[2][$];
   always @(negedge clock) begin
      int due;
      if (data_err_a) begin
         if (eq[0].size() == 0) check("unexpected_err_a", 32'd1, 32'd0);
         else begin due = eq[0].pop_front(); check("err_cycle_a", cyc, due); end
      end
      if (data_err_b) begin
         if (eq[1].size() == 0) check("unexpected_err_b", 32'd1, 32'd0);
         else begin due = eq[1].pop_front(); check("err_cycle_b", cyc, due); end
      end
   end
`endif

   typedef struct {
      bit          dreq;
      bit          dwe;
      logic [3:0]  be;
      logic [31:0] daddr;
      logic [31:0] wdata;
      bit          ireq;
      logic [31:0] iaddr;
      logic [31:0] exp_i;
      logic [31:0] exp_d;
      bit          exp_err;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit dreq, input bit dwe, input logic [3:0] be, input logic [31:0] daddr,
                      input logic [31:0] wdata, input bit ireq, input logic [31:0] iaddr,
                      input logic [31:0] exp_i, input logic [31:0] exp_d, input bit exp_err);
      tbl.push_back('{dreq: dreq, dwe: dwe, be: be, daddr: daddr, wdata: wdata, ireq: ireq,
                      iaddr: iaddr, exp_i: exp_i, exp_d: exp_d, exp_err: exp_err});
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
   endtask

   task automatic wait_init(input int r0, input string name);
      for (int k = 0; k < 4 * DEPTH && !init_done_a; k++) @(negedge clock);
      check({name, "_cycles"}, cyc - r0, DEPTH + 1);
      check({name, "_b"}, {31'd0, init_done_b}, 32'd1);
   endtask

   int          r0;
   logic [31:0] last_i, last_d;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted");
      $fatal(1);
   end

   initial begin
      // Vectors run in RUN state after the sweep; DEPTH=32 so 0x40 is word 16.
      add(1'b1, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 1'b1, 32'h0,  32'h0,        32'h0,        1'b0);
      add(1'b1, 1'b1, 4'h1, 32'h40, 32'h000000AA, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0);
      add(1'b1, 1'b0, 4'h0, 32'h40, 32'h0,        1'b1, 32'h40, 32'hDEADBEAA, 32'hDEADBEAA, 1'b0);
      add(1'b1, 1'b1, 4'hF, 32'h8,  32'h12345678, 1'b1, 32'h8,  32'h0,        32'h0,        1'b0);
      add(1'b1, 1'b0, 4'h0, 32'h8,  32'h0,        1'b1, 32'h8,  32'h12345678, 32'h12345678, 1'b0);
      add(1'b1, 1'b1, 4'hA, 32'h44, 32'hFFFFFFFF, 1'b1, 32'h0,  32'h0,        32'h0,        1'b0);
      add(1'b1, 1'b0, 4'h0, 32'h44, 32'h0,        1'b1, 32'h4,  32'h0,        32'hFF00FF00, 1'b0);
      add(1'b1, 1'b1, 4'h0, 32'h44, 32'h0,        1'b1, 32'h8,  32'h12345678, 32'h0,        1'b0);
      add(1'b1, 1'b0, 4'h0, 32'h44, 32'h0,        1'b1, 32'h44, 32'hFF00FF00, 32'hFF00FF00, 1'b0);
`ifdef MEM_ERR_EN
      add(1'b1, 1'b1, 4'hF, 32'h2,  32'hFFFFFFFF, 1'b1, 32'h0,  32'h0,        32'h0,        1'b1);
      add(1'b1, 1'b0, 4'h0, 32'h2,  32'h0,        1'b0, 32'h0,  32'h0,        32'h0,        1'b1);
      add(1'b1, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 32'h2,  32'h0,        32'h0,        1'b0);
      add(1'b1, 1'b0, 4'h0, 32'h80, 32'h0,        1'b0, 32'h0,  32'h0,        32'h0,        1'b1);
      add(1'b1, 1'b0, 4'h0, 32'h44, 32'h0,        1'b0, 32'h0,  32'h0,        32'hFF00FF00, 1'b0);
`else
      add(1'b1, 1'b0, 4'h0, 32'h80000047, 32'h0,        1'b0, 32'h0,  32'h0,        32'hFF00FF00, 1'b0);
      add(1'b1, 1'b1, 4'hF, 32'h10000003, 32'h0BADF00D, 1'b1, 32'h0,  32'h0,        32'h0,        1'b0);
      add(1'b1, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h80, 32'h0BADF00D, 32'h0BADF00D, 1'b0);
`endif

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_init_done_a", {31'd0, init_done_a}, 32'd0);
      check("rst_init_done_b", {31'd0, init_done_b}, 32'd0);
      check("rst_valids", {28'd0, inst_valid_a, data_valid_a, inst_valid_b, data_valid_b}, 32'd0);
      check("rst_inst_data_a", inst_data_a, 32'h0);
      check("rst_data_rdata_b", data_rdata_b, 32'h0);
`ifdef MEM_ERR_EN
      check("rst_err", {30'd0, data_err_a, data_err_b}, 32'd0);
`endif

      // Release reset; a write and an inst read during INIT must be dropped.
      @(posedge clock); #1;
      reset = 1'b0; r0 = cyc;
      data_req = 1'b1; data_we = 1'b1; data_be = 4'hF; data_addr = 32'hC; data_wdata = 32'hFFFFFFFF;
      inst_req = 1'b1; inst_addr = 32'hC;
      @(negedge clock);
      idle();
      wait_init(r0, "init");

      // Whole array reads zero on both ports.
      step();
      for (int i = 0; i < DEPTH; i++) begin
         data_req = 1'b1; data_we = 1'b0; data_addr = 32'(i * 4);
         inst_req = 1'b1; inst_addr = 32'((DEPTH - 1 - i) * 4);
         exp_inst(32'h0); exp_data(32'h0);
         step();
      end
      idle();
      repeat (4) step();

      // Table vectors
      last_i = 32'h0; last_d = 32'h0;
      for (int i = 0; i < tbl.size(); i++) begin
         vec_t r;
         r = tbl[i];
         data_req = r.dreq; data_we = r.dwe; data_be = r.be; data_addr = r.daddr; data_wdata = r.wdata;
         inst_req = r.ireq; inst_addr = r.iaddr;
         if (r.ireq) begin exp_inst(r.exp_i); last_i = r.exp_i; end
         if (r.dreq && !r.dwe) begin exp_data(r.exp_d); last_d = r.exp_d; end
`ifdef MEM_ERR_EN
         if (r.exp_err) begin eq[0].push_back(cyc + 1); eq[1].push_back(cyc + 2); end
`endif
         step();
      end
      idle();
      repeat (4) step();
      check("hold_inst_a", inst_data_a, last_i);
      check("hold_inst_b", inst_data_b, last_i);
      check("hold_data_a", data_rdata_a, last_d);
      check("hold_data_b", data_rdata_b, last_d);

      // Reset with reads in flight: no pulse, sweep restarts, array cleared.
      data_req = 1'b1; data_we = 1'b1; data_be = 4'hF; data_addr = 32'h14; data_wdata = 32'h55;
      step();
      data_we = 1'b0; inst_req = 1'b1; inst_addr = 32'h14;
      step();
      idle();
      reset = 1'b1;
      @(negedge clock);
      check("midrst_init_done", {30'd0, init_done_a, init_done_b}, 32'd0);
      check("midrst_valids", {28'd0, inst_valid_a, data_valid_a, inst_valid_b, data_valid_b}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0; r0 = cyc;
      wait_init(r0, "reinit");
      step();
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h14;
      inst_req = 1'b1; inst_addr = 32'h14;
      exp_inst(32'h0); exp_data(32'h0);
      step();
      idle();
      repeat (4) step();

      for (int p = 0; p < 4; p++) check($sformatf("pending_p%0d", p), q[p].size(), 32'd0);
`ifdef MEM_ERR_EN
      check("pending_err_a", eq[0].size(), 32'd0);
      check("pending_err_b", eq[1].size(), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
- Parametrised successor to the single-cycle unified memory.
- Provides a read-only instruction port and a read/write data port with byte strobes.
- Read latency is configurable; every read returns with a valid pulse.
- After reset, a sequencer clears the whole array and raises init_done.
- Sits between the fetch/load-store stages and backing storage.

Parameters:
DATA_W, 32, word width in bits; multiple of 8
DEPTH, 1024, number of words; power of two, >= 4
ADDR_W, 32, byte-address width on both ports
READ_LAT, 1, read latency in cycles; legal values 1 or 2

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
init_done  output  1  high once the clear sweep has finished; ports accept requests only while high
inst_req  input  1  instruction read request
inst_addr  input  ADDR_W  instruction byte address
inst_valid  output  1  one-cycle pulse when inst_data holds a result
inst_data  output  DATA_W  instruction read data
data_req  input  1  data port request
data_we  input  1  1 = write, 0 = read; sampled with data_req
data_be  input  DATA_W/8  byte write strobes; ignored on reads
data_addr  input  ADDR_W  data byte address
data_wdata  input  DATA_W  write data
data_valid  output  1  one-cycle pulse for read data only; writes give no response
data_rdata  output  DATA_W  data read result

Behaviour:
- Word index: IDX_W = log2(DEPTH); index = addr[IDX_W+1:2]. Bits [1:0] and bits above IDX_W+1 are ignored (base build).
- Reset values: init_done=0, inst_valid=0, data_valid=0, inst_data=0, data_rdata=0, sweep counter=0, read pipelines flushed, FSM=INIT.
- FSM has two states, INIT and RUN.
- INIT:
  - Writes 0 to word[counter] each cycle and increments the counter.
  - After writing word DEPTH-1 the FSM moves to RUN; init_done rises on the next edge (DEPTH+1 cycles after reset deassertion).
  - Requests on either port are dropped: no write, no valid.
- RUN, instruction read:
  - inst_req with index i is sampled at edge N.
  - inst_valid=1 and inst_data=word[i] after edge N+READ_LAT-1; with READ_LAT=1 they are visible after edge N.
  - Back-to-back requests give one result per cycle, in order.
- RUN, data read: same timing on data_valid / data_rdata.
- RUN, data write:
  - Committed at the sampling edge.
  - Byte k is updated only where data_be[k]=1; data_be=0 means no change.
- Between pulses: inst_data and data_rdata hold their last value, and the valid outputs are 0.
- Same-edge collision: data write and instruction read to the same word → instruction read returns the OLD word (read-first). A data read issued the cycle after the write returns the new word.
- READ_LAT=2: an extra output register stage on both ports. Collision rule unchanged.
- Reset mid-operation: in-flight reads are discarded and no valid is emitted; the FSM re-enters INIT and the array is re-cleared.

Optional Feature:
Macro MEM_ERR_EN.
- Defined:
  - Adds output data_err (1 bit, reset 0).
  - A data request is in error if addr[1:0]≠0 or any addr bit above IDX_W+1 is set.
  - An erroneous write is suppressed.
  - An erroneous read returns data_rdata=0.
  - In both cases data_err pulses high in the cycle a read's data_valid would occur; for writes data_valid stays 0.
  - The instruction port is unchecked.
- Undefined: no data_err port. Addresses are masked as in the base behaviour and no request is ever rejected.

Test Plan:
- Reset release, DEPTH=16 → init_done rises after exactly 17 cycles. Reads of all 16 words return 0. A data_req write during INIT is lost (later read returns 0).
- Write 0xDEADBEEF to 0x40 with be=4'hF, then byte-write 0x000000AA with be=4'b0001 → read of 0x40 returns 0xDEADBEAA with data_valid after READ_LAT cycles.
- Same edge: data write 0x12345678 to 0x8 and inst read of 0x8 (old 0x0) → inst_data=0x0. Inst read of 0x8 next cycle returns 0x12345678.
- Streaming inst reads of 0x0,0x4,0x8 on consecutive cycles, READ_LAT=2 → three consecutive inst_valid pulses with matching data, first pulse 2 cycles after the first request.
- Assert reset while a read is in flight → no valid pulse; init_done drops to 0, then returns after DEPTH+1 cycles; previously written word reads 0.
- MEM_ERR_EN: write to 0x2, then read 0x2 → data_err pulses on the read; word 0 is unchanged. Read of address DEPTH*4 → data_rdata=0, data_err=1.
